// File: rtl/os_ctrl_pkg.sv
// Shared definitions for the output-stationary array controller:
// state encoding and the skew/flush length added to every compute phase.
package os_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_COMPUTE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int DEF_ROWS  = 4;
   localparam int DEF_COLS  = 4;
   localparam int DEF_STAGE = 0;

   // Extra advancing cycles after the last operand: wavefront skew across
   // the array plus the multiplier pipeline.
   localparam int FLUSH_LEN = DEF_ROWS + DEF_COLS - 2 + DEF_STAGE;

   function automatic int flush_len(input int rows, input int cols, input int stage);
      return rows + cols - 2 + stage;
   endfunction

endpackage

// File: rtl/os_ctrl_counter.sv
// Enable-gated up-counter with synchronous clear and a terminal-count compare.
module os_ctrl_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic [W-1:0] count,
   output logic         at_last
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + W'(1);
      end
   end

   assign at_last = (count == last);

endmodule

// File: rtl/os_array_ctrl.sv
// Sequencer for an output-stationary systolic array: clear, stall-aware
// compute with skew flush, handshaked row drain, completion pulse.
module os_array_ctrl
   import os_ctrl_pkg::*;
#(
   parameter int ROWS    = 4,
   parameter int COLS    = 4,
   parameter int WIDTH_K = 8,
   parameter int STAGE   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [WIDTH_K-1:0]       k_len,
   input  logic                     stall,
   input  logic                     abort,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     reg_clear,
   output logic                     pipeline_en,
   output logic                     cell_en,
   output logic                     feed_req,
   output logic                     out_valid,
   output logic [$clog2(ROWS)-1:0]  out_row
);

   localparam int FLUSH   = flush_len(ROWS, COLS, STAGE);
   localparam int MAX_CNT = (2 ** WIDTH_K) - 1 + FLUSH;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int ROW_W   = $clog2(ROWS);

   state_e             state_q, state_d;
   logic [WIDTH_K-1:0] k_q;

   logic [CNT_W-1:0]   cmp_cnt, drn_cnt;
   logic [CNT_W-1:0]   cmp_last_val;
   logic               cmp_last, drn_last;
   logic               cmp_en, drn_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && start) begin
            k_q <= k_len;
         end
      end
   end

   // COMPUTE is only entered with k_q > 0, so the minus one cannot underflow.
   assign cmp_last_val = CNT_W'(k_q) + CNT_W'(FLUSH) - CNT_W'(1);

   // NOTE: every output and next-state is defaulted first so no path through
   // the case leaves a variable unassigned and infers a latch.
   always_comb begin
      state_d     = state_q;
      busy        = (state_q != ST_IDLE);
      done        = 1'b0;
      reg_clear   = 1'b0;
      pipeline_en = 1'b0;
      cell_en     = 1'b0;
      feed_req    = 1'b0;
      out_valid   = 1'b0;

      if (state_q != ST_IDLE && abort) begin
         reg_clear = 1'b1;
         state_d   = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
               reg_clear = 1'b1;
               state_d   = (k_q != '0) ? ST_COMPUTE : ST_DONE;
            end
            ST_COMPUTE: begin
               pipeline_en = !stall;
               cell_en     = !stall;
               if (!stall) begin
                  feed_req = (cmp_cnt < CNT_W'(k_q));
                  if (cmp_last) state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               out_valid   = 1'b1;
               pipeline_en = out_ready;
               if (out_ready && drn_last) state_d = ST_DONE;
            end
            ST_DONE: begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign cmp_en = (state_q == ST_COMPUTE) && pipeline_en;
   assign drn_en = out_valid && out_ready;

   // Counters idle at zero outside their own phase, so each phase starts clean.
   os_ctrl_counter #(.W(CNT_W)) u_cmp_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state_q != ST_COMPUTE),
      .en      (cmp_en),
      .last    (cmp_last_val),
      .count   (cmp_cnt),
      .at_last (cmp_last)
   );

   os_ctrl_counter #(.W(CNT_W)) u_drn_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state_q != ST_DRAIN),
      .en      (drn_en),
      .last    (CNT_W'(ROWS - 1)),
      .count   (drn_cnt),
      .at_last (drn_last)
   );

   // Rows leave bottom-up; the index is only meaningful while out_valid is high.
   assign out_row = out_valid ? ROW_W'(CNT_W'(ROWS - 1) - drn_cnt) : '0;

endmodule
